// File: rtl/br_cc_unit.sv
// rtl/br_cc_unit.sv - LC-3 NZP condition-code register and BR resolution unit
// Owns nzp, resolves BR against it and issues a one-cycle PC redirect when taken.
module br_cc_unit #(
  parameter int DATA_W = 16,
  parameter int OFF_W  = 9
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ld_cc,
  input  logic [DATA_W-1:0] bus_data,
  input  logic              br_start,
  input  logic [2:0]        ir_cond,
  input  logic [OFF_W-1:0]  pc_offset,
  input  logic [DATA_W-1:0] pc_in,
  output logic [2:0]        nzp,
  output logic              busy,
  output logic              pc_ld,
  output logic [DATA_W-1:0] pc_target,
  output logic              br_done,
  output logic              br_taken
);

  typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, DONE} state_t;

  state_t              state, state_nx;
  logic [2:0]          cond_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   pc_q;
  logic                taken_q;
  logic                taken_last;
  logic                taken_c;
  logic [DATA_W-1:0]   target_c;
  logic [2:0]          nzp_nx;

  always_comb begin
    nzp_nx = 3'b001;
    if (bus_data[DATA_W-1])
      nzp_nx = 3'b100;
    else if (bus_data == '0)
      nzp_nx = 3'b010;
  end

  // Evaluation sees the registered nzp, so a load coinciding with br_start is already visible.
  assign taken_c  = |(cond_q & nzp);
  assign target_c = pc_q + {{(DATA_W-OFF_W){off_q[OFF_W-1]}}, off_q};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (br_start) state_nx = EVAL;
      EVAL:     state_nx = taken_c ? REDIRECT : DONE;
      REDIRECT: state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Strobes decode straight from state so an asserted reset drops them immediately.
  always_comb begin
    busy     = (state != IDLE);
    pc_ld    = (state == REDIRECT);
    br_done  = (state == DONE);
    br_taken = (state == DONE) ? taken_q : taken_last;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      nzp        <= 3'b010;
      cond_q     <= '0;
      off_q      <= '0;
      pc_q       <= '0;
      taken_q    <= 1'b0;
      taken_last <= 1'b0;
      pc_target  <= '0;
    end else begin
      state <= state_nx;
      if (ld_cc)
        nzp <= nzp_nx;
      if (state == IDLE && br_start) begin
        cond_q <= ir_cond;
        off_q  <= pc_offset;
        pc_q   <= pc_in;
      end
      if (state == EVAL) begin
        taken_q   <= taken_c;
        pc_target <= target_c;
      end
      if (state == DONE)
        taken_last <= taken_q;
    end
  end

endmodule

// File: tb/tb_br_cc_unit.sv
// tb/tb_br_cc_unit.sv - scoreboard bench for br_cc_unit
module tb_br_cc_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        ld_cc = 1'b0;
  logic [15:0] bus_data = '0;
  logic        br_start = 1'b0;
  logic [2:0]  ir_cond = '0;
  logic [8:0]  pc_offset = '0;
  logic [15:0] pc_in = '0;
  logic [2:0]  nzp;
  logic        busy;
  logic        pc_ld;
  logic [15:0] pc_target;
  logic        br_done;
  logic        br_taken;

  br_cc_unit #(.DATA_W(16), .OFF_W(9)) dut (
    .Clk(Clk), .Reset(Reset), .ld_cc(ld_cc), .bus_data(bus_data),
    .br_start(br_start), .ir_cond(ir_cond), .pc_offset(pc_offset), .pc_in(pc_in),
    .nzp(nzp), .busy(busy), .pc_ld(pc_ld), .pc_target(pc_target),
    .br_done(br_done), .br_taken(br_taken)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          is_done;
    logic [15:0] val;
    int          cyc;
  } ev_t;

  ev_t sbq[$];
  int  cyc = 0;
  int  ntests = 0;
  int  nfail = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset) begin
      ev_t e;
      if (pc_ld && br_done) chk("pcld_done_overlap", 1, 0);
      if (pc_ld) begin
        if (sbq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_pc_ld: got pc_target %0h, expected no event", pc_target);
        end else begin
          e = sbq.pop_front();
          chk("pcld_kind", {31'd0, e.is_done}, 0);
          chk("pcld_target", pc_target, e.val);
          chk("pcld_cycle", cyc, e.cyc);
        end
      end
      if (br_done) begin
        if (sbq.size() == 0) begin
          ntests++; nfail++;
          $display("FAIL unexpected_br_done: got br_taken %0b, expected no event", br_taken);
        end else begin
          e = sbq.pop_front();
          chk("done_kind", {31'd0, e.is_done}, 1);
          chk("done_taken", br_taken, e.val);
          chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  // Expected events relative to the cycle in which br_start is driven.
  task automatic expect_br(input bit tk, input logic [15:0] tgt);
    if (tk) sbq.push_back('{is_done: 1'b0, val: tgt, cyc: cyc + 2});
    sbq.push_back('{is_done: 1'b1, val: {15'd0, tk}, cyc: cyc + (tk ? 3 : 2)});
  endtask

  task automatic wait_idle(input bit tk);
    int n = 0;
    while (busy && n < 8) begin
      tick;
      n++;
    end
    chk("idle_timeout", busy, 0);
    chk("br_taken_hold", br_taken, tk);
  endtask

  task automatic load(input logic [15:0] d, input logic [2:0] exp);
    ld_cc = 1'b1; bus_data = d;
    tick;
    ld_cc = 1'b0;
    chk("nzp_load", nzp, exp);
  endtask

  task automatic branch(input logic [2:0] cond, input logic [15:0] pc, input logic [8:0] off,
                        input bit tk, input logic [15:0] tgt);
    expect_br(tk, tgt);
    ir_cond = cond; pc_in = pc; pc_offset = off; br_start = 1'b1;
    tick;
    br_start = 1'b0;
    wait_idle(tk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) tick;
    chk("rst_nzp", nzp, 3'b010);
    chk("rst_busy", busy, 0);
    chk("rst_pc_ld", pc_ld, 0);
    chk("rst_br_done", br_done, 0);
    chk("rst_br_taken", br_taken, 0);
    chk("rst_pc_target", pc_target, 0);
    Reset = 1'b1;
    tick;

    load(16'h8000, 3'b100);
    load(16'h0000, 3'b010);
    load(16'h0001, 3'b001);

    branch(3'b001, 16'h3001, 9'h1FE, 1'b1, 16'h2FFF);
    load(16'hF123, 3'b100);
    branch(3'b011, 16'h3000, 9'h010, 1'b0, 16'h0000);
    branch(3'b000, 16'h3000, 9'h010, 1'b0, 16'h0000);
    branch(3'b111, 16'h1234, 9'h010, 1'b1, 16'h1244);
    branch(3'b100, 16'h2000, 9'h100, 1'b1, 16'h1F00);

    // ld_cc coinciding with br_start, then a load and new br_start during EVAL/REDIRECT
    expect_br(1'b1, 16'h4005);
    ld_cc = 1'b1; bus_data = 16'h0000;
    ir_cond = 3'b010; pc_in = 16'h4000; pc_offset = 9'h005; br_start = 1'b1;
    tick;
    bus_data = 16'h8000; ir_cond = 3'b000; pc_in = 16'h0000;
    tick;
    ld_cc = 1'b0;
    tick;
    br_start = 1'b0;
    wait_idle(1'b1);
    chk("nzp_after_eval_load", nzp, 3'b100);

    branch(3'b111, 16'hFFFF, 9'h001, 1'b1, 16'h0000);
    branch(3'b111, 16'h0000, 9'h1FF, 1'b1, 16'hFFFF);

    // Reset in REDIRECT aborts the resolution without any further events
    load(16'h0001, 3'b001);
    ir_cond = 3'b111; pc_in = 16'h5000; pc_offset = 9'h000; br_start = 1'b1;
    tick;
    br_start = 1'b0;
    tick;
    chk("redirect_pc_ld", pc_ld, 1);
    Reset = 1'b0;
    #1;
    chk("abort_pc_ld", pc_ld, 0);
    chk("abort_br_done", br_done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nzp", nzp, 3'b010);
    chk("abort_pc_target", pc_target, 0);
    chk("abort_br_taken", br_taken, 0);
    tick;
    tick;
    Reset = 1'b1;
    repeat (6) tick;
    chk("sb_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/br_cc_unit.md
Name: br_cc_unit

Overview:
- Producer side of the LC-3 branch-condition path: owns the NZP condition-code register and resolves BR instructions against it.
- Classifies the 16-bit bus value into N/Z/P on ld_cc.
- On br_start, captures the instruction's condition field, PC and PCoffset9, evaluates the condition, and issues a one-cycle PC redirect to PC + SEXT(offset9) when taken.
- Sits between the datapath bus and the ISDU/PC mux, handshaking with the ISDU via br_start, busy and br_done.

Parameters:
- DATA_W, 16, width of bus value, PC and target.
- OFF_W, 9, width of the signed PC offset field.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- ld_cc  input  1  load NZP from bus_data at the next edge.
- bus_data  input  DATA_W  value to classify (two's complement).
- br_start  input  1  begin a branch resolution; accepted only in IDLE.
- ir_cond  input  3  IR[11:9] condition mask {n,z,p}.
- pc_offset  input  OFF_W  IR[8:0], signed.
- pc_in  input  DATA_W  incremented PC of the branch instruction.
- nzp  output  3  current condition-code register {N,Z,P}.
- busy  output  1  high in every state except IDLE.
- pc_ld  output  1  one-cycle PC load strobe.
- pc_target  output  DATA_W  branch target; valid while pc_ld=1.
- br_done  output  1  one-cycle completion pulse.
- br_taken  output  1  result of the last resolution; held until the next resolution completes.

Behaviour:
- Reset (asynchronous assert, low) forces:
  - nzp=3'b010 and state=IDLE.
  - pc_ld=0, br_done=0, br_taken=0, pc_target=0, busy=0.
  - All captured fields are cleared.
  - Reset during any state aborts the resolution; no pc_ld or br_done is emitted for it.
- NZP register:
  - On an edge with ld_cc=1, nzp becomes 100 if bus_data[DATA_W-1]=1, 010 if bus_data==0, else 001.
  - nzp is always one-hot after reset.
  - ld_cc is honoured in every state.
- FSM states are IDLE, EVAL, REDIRECT, DONE.
- IDLE:
  - On br_start=1, capture ir_cond, pc_offset and pc_in, then go to EVAL.
  - Inputs are ignored while busy=1.
- EVAL (one cycle):
  - taken = |(cond_q & nzp), using the registered nzp visible in this cycle.
  - When ld_cc and br_start coincide, the newly loaded NZP is used.
  - An ld_cc asserted during EVAL does not affect this evaluation.
  - target = pc_q + sign-extend(off_q) to DATA_W, modulo 2^DATA_W; wrap-around is silent (x0000 - 1 = xFFFF).
  - Register target into pc_target.
  - If taken, go to REDIRECT; otherwise go to DONE.
- REDIRECT: pc_ld=1 for exactly one cycle with pc_target valid, then go to DONE.
- DONE:
  - br_done=1 for one cycle and br_taken is updated in this state.
  - Next state is IDLE. A br_start in that next IDLE cycle is accepted.
- Latency from br_start to br_done:
  - Taken branch: 3 cycles, with pc_ld on cycle 2.
  - Not-taken branch: 2 cycles.
- Condition-mask corner cases: cond=000 is never taken (NOP); cond=111 is always taken.
- pc_ld and br_done are never high in the same cycle.

Test Plan:
- Reset release -> nzp=010, busy=0, pc_ld=0, br_done=0, br_taken=0.
- ld_cc with bus_data=x8000, then x0000, then x0001 -> nzp=100, 010, 001 on successive cycles.
- nzp=001, br_start with ir_cond=001, pc_in=x3001, pc_offset=0x1FE (-2) -> pc_ld pulse with pc_target=x2FFF two cycles later, br_done next cycle, br_taken=1.
- nzp=100, ir_cond=011 -> no pc_ld, br_done 2 cycles after start, br_taken=0. Also ir_cond=000 with any nzp -> not taken; ir_cond=111 -> taken.
- ld_cc with bus_data=0 in the same cycle as br_start with ir_cond=010 -> taken. A second br_start while busy is ignored (exactly one br_done observed).
- Wrap-around: pc_in=xFFFF, pc_offset=x001 -> pc_target=x0000. Reset asserted mid-REDIRECT -> pc_ld and br_done drop immediately, nzp=010, no br_done afterwards.
